// File: rtl/debounce_pkg.sv
// debounce_pkg: shared constants and helpers for the switch debounce bank.
//   DEFAULT_DEBOUNCE_LIMIT : 10 ms at 25 MHz
//   DEFAULT_HOLD_LIMIT     : 1 s at 25 MHz
//   DEFAULT_SYNC_STAGES    : synchroniser depth
//   clog2(v)               : bits needed to count 0..v-1 (never less than 1)
package debounce_pkg;

  localparam int DEFAULT_DEBOUNCE_LIMIT = 250000;
  localparam int DEFAULT_HOLD_LIMIT     = 25000000;
  localparam int DEFAULT_SYNC_STAGES    = 2;

  // Counter widths are taken as clog2(LIMIT+1); a minimum of one bit keeps
  // the HOLD_LIMIT=0 (disabled) case from producing a zero-width vector.
  function automatic int clog2(input int v);
    int w;
    w = 1;
    while ((64'(1) << w) < 64'(v)) w++;
    return w;
  endfunction

endpackage

// File: rtl/debounce_bank_if.sv
// debounce_bank_if: switch inputs and debounced event outputs of the bank.
//   i_switch    : raw asynchronous switch levels, 1 = pressed
//   o_switch    : debounced level per channel
//   o_press     : one-cycle pulse on debounced 0->1
//   o_release   : one-cycle pulse on debounced 1->0
//   o_hold      : one-cycle pulse when a press has lasted HOLD_LIMIT cycles
//   o_any_event : OR of all press/release/hold bits
// master = switch source / event consumer, slave = the debounce bank.
interface debounce_bank_if #(
  parameter int N_CHANNELS = 4
);
  logic [N_CHANNELS-1:0] i_switch;
  logic [N_CHANNELS-1:0] o_switch;
  logic [N_CHANNELS-1:0] o_press;
  logic [N_CHANNELS-1:0] o_release;
  logic [N_CHANNELS-1:0] o_hold;
  logic                  o_any_event;

  modport master (
    output i_switch,
    input  o_switch, o_press, o_release, o_hold, o_any_event
  );

  modport slave (
    input  i_switch,
    output o_switch, o_press, o_release, o_hold, o_any_event
  );
endinterface

// File: rtl/debounce_channel.sv
// debounce_channel: one switch channel.
//   clock, reset : system clock, async active-high reset
//   raw          : asynchronous switch level
//   level        : debounced level
//   press, rel   : registered one-cycle pulses on debounced rise / fall
//   hold         : registered one-cycle pulse once a press lasts HOLD_LIMIT cycles
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
  parameter int HOLD_LIMIT     = DEFAULT_HOLD_LIMIT,
  parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic hold
);

  localparam int DW = clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_LIMIT - 1);

  // Synchroniser as a shift register; only the last stage is used.
  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   sync;

  assign sync = sync_pipe[SYNC_STAGES-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_pipe <= '0;
    else       sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], raw};
  end

  // Debounce: count consecutive cycles where sync disagrees with level; any
  // agreeing cycle restarts the count, so glitches shorter than the limit die.
  logic [DW-1:0] db_cnt;
  logic          accept;

  assign accept = (sync != level) && (db_cnt == DB_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      db_cnt <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
      rel    <= 1'b0;
    end else begin
      // Pulses are registered alongside level so they coincide with it.
      press <= accept &  sync;
      rel   <= accept & ~sync;
      if (sync == level) begin
        db_cnt <= '0;
      end else if (accept) begin
        level  <= sync;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Hold detection: saturating press-duration counter.
  if (HOLD_LIMIT > 0) begin : g_hold
    localparam int HW = clog2(HOLD_LIMIT + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_LIMIT);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_LIMIT - 1);

    logic [HW-1:0] hold_cnt;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        hold_cnt <= '0;
        hold     <= 1'b0;
      end else begin
        // Fires on the edge the counter reaches HOLD_MAX; saturation makes
        // this at most once per press.
        hold <= level && (hold_cnt == HOLD_LAST);
        if (!level)                   hold_cnt <= '0;
        else if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end else begin : g_no_hold
    assign hold = 1'b0;
  end

endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: N_CHANNELS independent switch debouncers with press,
// release and hold event pulses.
//   clock : system clock (rising edge)
//   reset : asynchronous active-high reset
//   bus   : debounce_bank_if slave port (i_switch in; o_switch, o_press,
//           o_release, o_hold, o_any_event out)
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N_CHANNELS     = 4,
  parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
  parameter int HOLD_LIMIT     = DEFAULT_HOLD_LIMIT,
  parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES
) (
  input logic            clock,
  input logic            reset,
  debounce_bank_if.slave bus
);

  logic [N_CHANNELS-1:0] level;
  logic [N_CHANNELS-1:0] press;
  logic [N_CHANNELS-1:0] rel;
  logic [N_CHANNELS-1:0] hold;

  for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT),
      .HOLD_LIMIT    (HOLD_LIMIT),
      .SYNC_STAGES   (SYNC_STAGES)
    ) u_ch (
      .clock(clock),
      .reset(reset),
      .raw  (bus.i_switch[i]),
      .level(level[i]),
      .press(press[i]),
      .rel  (rel[i]),
      .hold (hold[i])
    );
  end

  assign bus.o_switch    = level;
  assign bus.o_press     = press;
  assign bus.o_release   = rel;
  assign bus.o_hold      = hold;
  // Combinational OR of registered pulses: clears with reset immediately.
  assign bus.o_any_event = |{press, rel, hold};

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed scenarios plus random switch activity on the
// debounce bank, checked every cycle against a sliding-window reference.
module tb_debounce_bank;

  localparam int NC  = 4;
  localparam int DL  = 4;
  localparam int HL  = 10;
  localparam int SS  = 2;
  localparam int WIN = SS + DL;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_HOLD  = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  debounce_bank_if #(.N_CHANNELS(NC)) bus ();

  debounce_bank #(
    .N_CHANNELS    (NC),
    .DEBOUNCE_LIMIT(DL),
    .HOLD_LIMIT    (HL),
    .SYNC_STAGES   (SS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference: hist[c][j] is the input sampled j edges ago. The debounced
  // level flips when the DL samples seen SS..SS+DL-1 edges ago all disagree
  // with it. Hold fires HL edges after the press edge if still pressed.
  bit [WIN-1:0] hist [NC];
  bit [NC-1:0]  m_sw, m_pr, m_rl, m_hd;
  int           press_edge [NC];
  int           edge_n;
  int           n_press [NC];
  int           n_rel   [NC];
  int           n_hold  [NC];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      hist[c]       = '0;
      press_edge[c] = -100000;
    end
    m_sw = '0; m_pr = '0; m_rl = '0; m_hd = '0;
  endtask

  task automatic clear_counts();
    for (int c = 0; c < NC; c++) begin
      n_press[c] = 0; n_rel[c] = 0; n_hold[c] = 0;
    end
  endtask

  task automatic model_edge(input logic [NC-1:0] in);
    edge_n++;
    for (int c = 0; c < NC; c++) begin
      bit          old;
      bit          flip;
      bit [DL-1:0] win;
      old     = m_sw[c];
      hist[c] = {hist[c][WIN-2:0], bit'(in[c])};
      win     = hist[c][WIN-1:SS];
      flip    = old ? (win == '0) : (win == '1);
      m_hd[c] = old && ((edge_n - press_edge[c]) == HL);
      m_pr[c] = flip && !old;
      m_rl[c] = flip && old;
      if (flip) m_sw[c] = !old;
      if (flip && !old) press_edge[c] = edge_n;
    end
  endtask

  task automatic compare_all();
    chk("o_switch",    bus.o_switch,    m_sw);
    chk("o_press",     bus.o_press,     m_pr);
    chk("o_release",   bus.o_release,   m_rl);
    chk("o_hold",      bus.o_hold,      m_hd);
    chk("o_any_event", bus.o_any_event, |{m_pr, m_rl, m_hd});
  endtask

  // One clock edge: update the model from the sampled inputs, then check
  // the DUT 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    if (reset) model_reset();
    else       model_edge(bus.i_switch);
    #1;
    compare_all();
    for (int c = 0; c < NC; c++) begin
      n_press[c] += int'(bus.o_press[c]);
      n_rel[c]   += int'(bus.o_release[c]);
      n_hold[c]  += int'(bus.o_hold[c]);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Ticks until the selected pulse appears on channel ch; returns the number
  // of edges taken, or -1 if it never came within the budget.
  task automatic wait_for(input int ch, input int kind, output int lat);
    bit seen;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      case (kind)
        K_PRESS: seen = bus.o_press[ch];
        K_REL:   seen = bus.o_release[ch];
        default: seen = bus.o_hold[ch];
      endcase
      if (seen) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic [NC-1:0] pv;

    edge_n = 0;
    model_reset();
    clear_counts();
    reset = 1'b1;
    bus.i_switch = '0;
    repeat (3) @(posedge clock);
    #1;
    compare_all();
    #2 reset = 1'b0;

    // Clean press on channel 0.
    bus.i_switch = 4'b0001;
    wait_for(0, K_PRESS, lat);
    chk("clean_press_latency", lat, 6);
    chk("clean_press_any", bus.o_any_event, 1'b1);
    chk("clean_press_level", bus.o_switch[0], 1'b1);
    bus.i_switch = '0;
    ticks(20);

    // Bounce on channel 1: 1,0,1 each held 3 cycles, then held at 1.
    clear_counts();
    bus.i_switch = 4'b0010; ticks(3);
    bus.i_switch = 4'b0000; ticks(3);
    bus.i_switch = 4'b0010;
    chk("bounce_no_early_press", n_press[1], 0);
    wait_for(1, K_PRESS, lat);
    chk("bounce_press_latency", lat, 6);
    bus.i_switch = '0;
    ticks(20);

    // Long press on channel 2.
    clear_counts();
    bus.i_switch = 4'b0100;
    wait_for(2, K_PRESS, lat);
    chk("long_press_latency", lat, 6);
    wait_for(2, K_HOLD, lat);
    chk("hold_after_press", lat, 10);
    ticks(15);
    bus.i_switch = '0;
    wait_for(2, K_REL, lat);
    chk("long_release_latency", lat, 6);
    ticks(15);
    chk("long_hold_count", n_hold[2], 1);

    // Short press on channel 3.
    clear_counts();
    bus.i_switch = 4'b1000; ticks(8);
    bus.i_switch = '0; ticks(20);
    chk("short_press_count", n_press[3], 1);
    chk("short_release_count", n_rel[3], 1);
    chk("short_hold_count", n_hold[3], 0);

    // Simultaneous rise on all channels.
    bus.i_switch = 4'b1111;
    lat = -1;
    pv  = '0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.o_press != '0) begin
        lat = k;
        pv  = bus.o_press;
        break;
      end
    end
    chk("simul_press_latency", lat, 6);
    chk("simul_press_vector", pv, 4'b1111);
    bus.i_switch = '0;
    ticks(25);

    // Reset mid-debounce with channel 1 already pressed.
    bus.i_switch = 4'b0010;
    ticks(10);
    bus.i_switch = 4'b0011;
    ticks(2);
    #1 reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    repeat (2) @(posedge clock);
    #3 reset = 1'b0;
    wait_for(0, K_PRESS, lat);
    chk("post_reset_press_latency", lat, 6);
    chk("post_reset_press_ch1", bus.o_press[1], 1'b1);
    bus.i_switch = '0;
    ticks(20);

    // Random activity with sticky levels, one asynchronous reset midway.
    for (int i = 0; i < 1500; i++) begin
      logic [NC-1:0] nx;
      nx = bus.i_switch;
      for (int c = 0; c < NC; c++)
        if ($urandom_range(0, 5) == 0) nx[c] = ~nx[c];
      bus.i_switch = nx;
      if (i == 750) begin
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clock);
        #3 reset = 1'b0;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 The block SHALL take parameter N_CHANNELS, default 4, giving the number of independent switch channels (1..32).
REQ-002 The block SHALL take parameter DEBOUNCE_LIMIT, default 250000, giving the consecutive stable cycles required to accept a change (10 ms at 25 MHz; minimum 1).
REQ-003 The block SHALL take parameter HOLD_LIMIT, default 25000000, giving the cycles a switch must stay pressed before a hold event (1 s at 25 MHz); 0 disables hold detection.
REQ-004 The block SHALL take parameter SYNC_STAGES, default 2, giving the synchroniser depth per channel (minimum 2).
REQ-005 clock  input  1  single system clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 i_switch  input  N_CHANNELS  raw asynchronous switch levels, 1 = pressed.
REQ-008 o_switch  output  N_CHANNELS  debounced level per channel.
REQ-009 o_press  output  N_CHANNELS  one-cycle pulse when the debounced level goes 0->1.
REQ-010 o_release  output  N_CHANNELS  one-cycle pulse when the debounced level goes 1->0.
REQ-011 o_hold  output  N_CHANNELS  one-cycle pulse when a press has lasted HOLD_LIMIT cycles.
REQ-012 o_any_event  output  1  OR of all bits of o_press, o_release and o_hold in the same cycle.

Function
REQ-013 Each channel SHALL pass i_switch through SYNC_STAGES flip-flops; only the last stage (sync) feeds debounce logic.
REQ-014 Each channel SHALL hold a counter of width clog2(DEBOUNCE_LIMIT+1) bits, which increments every cycle sync differs from o_switch.
REQ-015 Any cycle in which sync equals o_switch SHALL clear that channel's counter to 0 (glitch rejection).
REQ-016 When sync differs from o_switch and the counter equals DEBOUNCE_LIMIT-1, the next edge SHALL load o_switch with sync and clear the counter.
REQ-017 An input change stable from before edge k SHALL therefore appear on o_switch after edge k+SYNC_STAGES+DEBOUNCE_LIMIT-1, i.e. SYNC_STAGES+DEBOUNCE_LIMIT edges of latency.
REQ-018 o_press and o_release SHALL assert in the same cycle that the new o_switch value first appears, for exactly one cycle, and are registered outputs.
REQ-019 Each channel SHALL hold a saturating hold counter of width clog2(HOLD_LIMIT+1) bits, which increments while o_switch=1 and clears while o_switch=0.
REQ-020 When the hold counter reaches HOLD_LIMIT, o_hold SHALL pulse for one cycle; the counter then saturates so only one hold pulse occurs per press.
REQ-021 A release before HOLD_LIMIT SHALL produce no hold pulse; a release after hold SHALL still produce o_release.
REQ-022 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.
REQ-023 Counters SHALL never wrap; the debounce counter never exceeds DEBOUNCE_LIMIT-1, and the hold counter stops at HOLD_LIMIT.

Reset
REQ-024 While reset is high, all synchroniser stages, counters, o_switch, o_press, o_release, o_hold and o_any_event SHALL be 0 immediately, without waiting for a clock edge.
REQ-025 Reset asserted mid-debounce or mid-hold SHALL discard the partial count; after release, an input held at 1 SHALL need the full SYNC_STAGES+DEBOUNCE_LIMIT edges before o_press.
REQ-026 Reset deassertion SHALL be synchronised externally; the block does not generate any pulse on reset exit.

Structure
REQ-027 The package debounce_pkg SHALL hold default limit constants (DEFAULT_DEBOUNCE_LIMIT, DEFAULT_HOLD_LIMIT) and the clog2 width function.
REQ-028 Per-channel logic SHALL live in the sub-module debounce_channel (synchroniser, both counters and event pulses), instantiated N_CHANNELS times by a generate loop; o_any_event is formed at the top level.

Verification (N_CHANNELS=4, DEBOUNCE_LIMIT=4, HOLD_LIMIT=10, SYNC_STAGES=2)
REQ-029 Clean press: i_switch[0] 0->1 held -> o_switch[0]=1 and o_press[0]=1 for one cycle exactly 6 edges later, with o_any_event=1 in the same cycle.
REQ-030 Bounce: i_switch[1] toggles 1,0,1 with each level held 3 cycles, then held at 1 -> no o_press until 6 edges after the final rise.
REQ-031 Long press: hold i_switch[2]=1 -> o_hold[2] pulses once, 10 cycles after o_press[2]; release -> o_release[2] 6 edges later, with no second hold pulse.
REQ-032 Short press: i_switch[3]=1 for 8 cycles -> o_press and o_release both pulse, o_hold never asserts.
REQ-033 Simultaneous: all four inputs rise on the same cycle -> o_press=4'b1111 in a single cycle.
REQ-034 Reset mid-operation: assert reset 2 cycles into a debounce -> all outputs 0 asynchronously; after reset exits with the input still 1, o_press arrives 6 edges later.
